// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_pkg: shared state type and counter sizing for the FIFO stream reader
package fifo_stream_pkg;
    typedef enum logic {RUN, PAD} rd_state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port, output stream and flush/busy control bundle
interface fifo_stream_reader_if #(parameter int WIDTH = 8);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             flush;
    logic             busy;
    modport master (
        input  fifo_empty, fifo_rd_data, m_ready, flush,
        output fifo_rd_en, m_valid, m_data, m_last, busy
    );
    modport slave (
        output fifo_empty, fifo_rd_data, m_ready, flush,
        input  fifo_rd_en, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/fifo_stream_reader_skid2.sv
// stream_skid2: two-entry registered buffer whose head only changes when popped
module stream_skid2 import fifo_stream_pkg::*; #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok, push_ok;
    always_comb begin
        pop_ok  = pop & (count_q != 2'd0);
        push_ok = push & ((count_q != 2'd2) | pop_ok);
        head_d  = (pop_ok & (count_q == 2'd2)) ? tail_q :
                  (push_ok & ((count_q == 2'd0) | (pop_ok & (count_q == 2'd1)))) ? push_data : head_q;
        tail_d  = (push_ok & (((count_q == 2'd1) & ~pop_ok) | (count_q == 2'd2))) ? push_data : tail_q;
        count_d = count_q + 2'(push_ok) - 2'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    assign head_data = head_q;
    assign count     = count_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO into a packet-framed valid/ready stream with flush padding
module fifo_stream_reader import fifo_stream_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input logic                  clk,
    input logic                  reset,
    fifo_stream_reader_if.master bus
);
    localparam int            CW       = cnt_w(PKT_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);
    rd_state_t      state_q, state_d;
    logic [CW-1:0]  in_cnt_q, in_cnt_d;
    logic [1:0]     count;
    logic [WIDTH:0] head, push_data;
    logic           rd_en, pad_push, push, in_last, pop;
    // FIFO reads depend only on buffer room, never on m_ready
    always_comb begin
        in_last   = in_cnt_q == LAST_CNT;
        rd_en     = reset & ~bus.fifo_empty & (state_q == RUN) & (count < 2'd2);
        pad_push  = (state_q == PAD) & (count < 2'd2);
        push      = rd_en | pad_push;
        push_data = {in_last, (state_q == PAD) ? {WIDTH{1'b0}} : bus.fifo_rd_data};
        in_cnt_d  = push ? (in_last ? '0 : in_cnt_q + CW'(1)) : in_cnt_q;
        state_d   = ((state_q == RUN) & bus.flush & (in_cnt_d != '0)) ? PAD :
                    ((state_q == PAD) & pad_push & in_last) ? RUN : state_q;
        pop       = (count != 2'd0) & bus.m_ready;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RUN;
            in_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
        end
    end
    stream_skid2 #(.W(WIDTH + 1)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = count != 2'd0;
    assign bus.m_data     = head[WIDTH-1:0];
    assign bus.m_last     = head[WIDTH];
    assign bus.busy       = (state_q == PAD) | (count != 2'd0);
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scenario tasks against a FIFO model and a packet-framing reference queue
module tb_fifo_stream_reader;
    localparam int W = 8;
    localparam int P = 4;
    logic clk;
    logic reset;
    fifo_stream_reader_if #(.WIDTH(W)) bus ();
    fifo_stream_reader #(.WIDTH(W), .PKT_LEN(P)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [W-1:0] mem [256];
    int wr_ptr, rd_ptr, pops, cyc, mpos, n_cmp, n_err;
    bit rd_pend, rand_ready;
    logic [W-1:0] got_d[$], exp_d[$];
    logic got_l[$], exp_l[$];
    int got_c[$], pop_c[$];
    initial clk = 0;
    always #5 clk = ~clk;
    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = mem[rd_ptr[7:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_pend) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end
    always @(negedge clk) begin
        rd_pend = bus.fifo_rd_en === 1'b1;
        if (rd_pend) pop_c.push_back(cyc);
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            got_d.push_back(bus.m_data);
            got_l.push_back(bus.m_last);
            got_c.push_back(cyc);
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end
    // reference: every word in FIFO order, last on each P-th entry, flush pads zeros to the boundary
    task automatic model_word(input logic [W-1:0] w);
        exp_d.push_back(w);
        exp_l.push_back(mpos == P - 1);
        mpos = (mpos + 1) % P;
    endtask
    task automatic model_flush();
        while (mpos != 0) model_word('0);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    endtask
    task automatic put(input logic [W-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask
    task automatic pulse_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask
    task automatic wait_for(input bit idle, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = bus.fifo_empty && (!idle || bus.busy === 1'b0);
            step();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_timeout idle=%0b: condition not reached in %0d cycles", idle, budget);
        end
    endtask
    task automatic drain();
        rand_ready = 0;
        bus.m_ready = 1'b1;
        wait_for(1, 300);
    endtask
    task automatic test_reset();
        int gs, p0;
        bit ok;
        reset = 1'b0;
        bus.m_ready = 1'b1;
        bus.flush = 1'b0;
        rand_ready = 0;
        for (int i = 0; i < 8; i++) begin
            put(8'(8'h11 + i));
            model_word(8'(8'h11 + i));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b expected 0", bus.fifo_rd_en); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b expected 0", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 8'h00) begin n_err++; $display("FAIL reset_m_data got %h expected 00", bus.m_data); end
        n_cmp++; if (bus.m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last got %b expected 0", bus.m_last); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        n_cmp++; if (pops != 0) begin n_err++; $display("FAIL reset_pops got %0d expected 0", pops); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        gs = got_d.size();
        p0 = pop_c.size();
        drain();
        n_cmp++;
        if (got_d.size() != gs + 8) begin n_err++; $display("FAIL reset_stream_count got %0d expected 8", got_d.size() - gs); end
        for (int i = 0; i < 8 && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[i] || got_l[gs+i] !== exp_l[i]) begin
                n_err++;
                $display("FAIL reset_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[i], exp_l[i]);
            end
        end
        ok = got_d.size() == gs + 8 && pop_c.size() > p0 && got_c[gs] == pop_c[p0] + 1;
        for (int i = 0; ok && i < 8; i++) ok = got_c[gs+i] == got_c[gs] + i;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL reset_timing got beats not one per cycle from first pop + 1, expected consecutive"); end
    endtask
    task automatic test_backpressure();
        int gs, es, p0;
        logic [W-1:0] first;
        gs = got_d.size();
        es = exp_d.size();
        p0 = pops;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] w = 8'($urandom);
            if (i == 0) first = w;
            put(w);
            model_word(w);
        end
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (pops - p0 != 2) begin n_err++; $display("FAIL bp_pops got %0d expected 2", pops - p0); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en got %b expected 0", bus.fifo_rd_en); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== first) begin
                n_err++;
                $display("FAIL bp_hold%0d got valid=%b data=%h expected valid=1 data=%h", i, bus.m_valid, bus.m_data, first);
            end
        end
        step();
        rand_ready = 1;
        repeat (10) step();
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL bp_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL bp_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    task automatic test_flush_pad();
        int gs, es;
        gs = got_d.size();
        es = exp_d.size();
        put(8'hA1); model_word(8'hA1);
        put(8'hA2); model_word(8'hA2);
        wait_for(0, 50);
        pulse_flush();
        model_flush();
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL pad_busy got %b expected 1", bus.busy); end
        step();
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL pad_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL pad_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    task automatic test_flush_on_last();
        int gs, es, p0;
        bit hit = 0;
        gs = got_d.size();
        es = exp_d.size();
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            put(8'(8'hB0 + i));
            model_word(8'(8'hB0 + i));
        end
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en === 1'b1 && pops == p0 + 3) begin
                bus.flush = 1'b1;
                hit = 1;
            end
            step();
            bus.flush = 1'b0;
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL last_flush_timing got no 4th pop, expected one within 30 cycles"); end
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL last_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL last_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    task automatic test_flush_idle();
        int gs, es;
        gs = got_d.size();
        es = exp_d.size();
        pulse_flush();
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b expected 0", bus.busy); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL idle_m_valid got %b expected 0", bus.m_valid); end
        step();
        put(8'h5A);
        model_word(8'h5A);
        @(negedge clk);
        n_cmp++; if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL idle_rd_en got %b expected 1", bus.fifo_rd_en); end
        step();
        pulse_flush();
        model_flush();
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL idle_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL idle_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    task automatic test_random();
        int gs, es;
        gs = got_d.size();
        es = exp_d.size();
        rand_ready = 1;
        for (int r = 0; r < 25; r++) begin
            int k = $urandom_range(0, 6);
            for (int i = 0; i < k; i++) begin
                logic [W-1:0] w = 8'($urandom);
                put(w);
                model_word(w);
            end
            wait_for(0, 100);
            if ($urandom_range(0, 1) == 1) begin
                pulse_flush();
                model_flush();
            end
            repeat ($urandom_range(0, 3)) step();
        end
        pulse_flush();
        model_flush();
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL rand_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL rand_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    task automatic test_reset_mid_pad();
        int gs, es, p0;
        rand_ready = 0;
        bus.m_ready = 1'b0;
        put(8'hC3);
        wait_for(0, 20);
        pulse_flush();
        for (int i = 0; i < 4; i++) put(8'(8'hD0 + i));
        repeat (3) step();
        p0 = pops;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== 8'hC3) begin
            n_err++;
            $display("FAIL midpad_state got busy=%b valid=%b data=%h expected 1 1 c3", bus.busy, bus.m_valid, bus.m_data);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL midpad_reset_rd_en got %b expected 0", bus.fifo_rd_en); end
        step();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL midpad_after_valid got %b expected 0", bus.m_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midpad_after_busy got %b expected 0", bus.busy); end
        n_cmp++; if (pops != p0) begin n_err++; $display("FAIL midpad_pops got %0d expected %0d", pops, p0); end
        step();
        gs = got_d.size();
        es = exp_d.size();
        mpos = 0;
        for (int i = 0; i < 4; i++) model_word(8'(8'hD0 + i));
        drain();
        n_cmp++;
        if (got_d.size() - gs != exp_d.size() - es) begin n_err++; $display("FAIL midpad_stream_count got %0d expected %0d", got_d.size() - gs, exp_d.size() - es); end
        for (int i = 0; i < exp_d.size() - es && gs + i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[gs+i] !== exp_d[es+i] || got_l[gs+i] !== exp_l[es+i]) begin
                n_err++;
                $display("FAIL midpad_stream_beat%0d got %h/%b expected %h/%b", i, got_d[gs+i], got_l[gs+i], exp_d[es+i], exp_l[es+i]);
            end
        end
    endtask
    initial begin
        test_reset();
        test_backpressure();
        test_flush_pad();
        test_flush_on_last();
        test_flush_idle();
        test_random();
        test_reset_mid_pad();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drains the read port of the team's synchronous show-ahead FIFO (`empty`, `rd_en`, `rd_data` valid whenever not empty) and presents the words as a valid/ready stream framed into fixed-length packets. It sits on the consumer side of the FIFO and drives downstream stream logic. It decouples `m_ready` from `fifo_rd_en` through a registered 2-entry buffer. A `flush` request closes a partial packet by zero-padding it to `PKT_LEN` beats.

## Interface
Parameters:
- WIDTH, 8, data word width; must equal the FIFO WIDTH
- PKT_LEN, 4, beats per packet, ≥1; counter width CW = max(1, $clog2(PKT_LEN))

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  WIDTH  FIFO head word, valid when fifo_empty=0
- fifo_rd_en  out  1  pop request to FIFO; a pop occurs at the edge when fifo_rd_en=1
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH  output beat data
- m_last  out  1  final beat of the packet
- flush  in  1  single-cycle request to close the current partial packet
- busy  out  1  state=PAD or buffer not empty

## Operation
- Buffer: 2 entries {data, last}, occupancy `count` ∈ {0,1,2}. Push and pop in the same cycle leave `count` unchanged.
- fifo_rd_en = reset & ~fifo_empty & (state==RUN) & (count<2). It is a function of `count` and `fifo_empty` only and has no path from m_ready.
- Push on fifo_rd_en: entry = {fifo_rd_data, in_cnt==PKT_LEN-1}. Then in_cnt = (in_cnt==PKT_LEN-1) ? 0 : in_cnt+1.
- m_valid = count!=0. m_data and m_last come from the head entry. Pop when m_valid & m_ready.
- State machine: RUN, PAD.
  - RUN→PAD: flush=1, and in_cnt after this cycle's push is ≠0.
  - If that in_cnt is 0, including the case where the flush-cycle push completed the packet, flush is ignored.
  - PAD: no FIFO reads. When count<2, push {0, in_cnt==PKT_LEN-1} and advance in_cnt.
  - PAD→RUN: on the cycle the last-flagged pad entry is pushed.
- flush is ignored while in PAD. flush with PKT_LEN=1 is always a no-op.
- Output beats: data is held stable while m_valid=1 and m_ready=0. The head entry never changes until it is popped.
- Reset (reset=0 at an edge) takes effect mid-packet and mid-PAD. Buffer entries and the in-flight pad are discarded, not drained. No FIFO pop occurs during the reset cycle.

## Timing
- Reset values: count=0, in_cnt=0, state=RUN. m_valid=0, m_data=0, m_last=0, busy=0. fifo_rd_en=0 while reset=0.
- Latency: a FIFO word popped at edge N is on m_data with m_valid=1 from cycle N+1.
- Throughput: 1 beat/cycle sustained with m_ready=1 and a non-empty FIFO; steady state is count=1.
- Backpressure: with m_ready=0, at most 2 words are popped before fifo_rd_en drops.
- Flush at cycle N: the state is PAD from N+1. Padding runs at 1 beat/cycle when unstalled. The first pad beat reaches the output at N+2 at the earliest.
- Packet boundary: every PKT_LEN-th pushed entry carries last=1, whether data or pad.

## Structure
- Package `fifo_stream_pkg`: `typedef enum logic {RUN, PAD} rd_state_t`, and a struct `stream_entry_t` parameterised via WIDTH (or a packed {last, data} vector of WIDTH+1).
- Sub-module `stream_skid2`: a generic 2-entry registered buffer on WIDTH+1 bits.
  - Ports: push, push_data, pop, head_data, count.
  - The top level holds the state machine, in_cnt and fifo_rd_en logic.

## Test plan
- Reset with the FIFO preloaded 0x11..0x18 and m_ready=1, PKT_LEN=4. Expect beats 0x11..0x18 on consecutive cycles from cycle 1 after the first pop, with m_last on 0x14 and 0x18.
- Hold m_ready=0 with 8 words queued. Expect exactly 2 pops, then fifo_rd_en=0. m_data holds the first word and m_valid stays 1. Releasing m_ready resumes in order with no loss or duplicate.
- Push 2 words (0xA1, 0xA2), then pulse flush. Expect beats 0xA1, 0xA2, 0x00, 0x00 with m_last on the final 0x00, then busy=0.
- Pulse flush on the cycle the 4th packet word is popped. Expect no padding and state to remain RUN.
- Pulse flush with in_cnt=0 and the buffer empty. Expect no output beats, fifo_rd_en unaffected, and busy=0.
- Assert reset=0 mid-PAD with count=2. Expect the next cycle to show m_valid=0 and fifo_rd_en=0. After release, the next packet starts at in_cnt=0 (last on its 4th beat).
